instr_queue: RTL
================

# instr_queue

Instruction queue between the fetch unit and decode. Each accepted fetch beat writes two 32-bit instructions. Decode reads the two oldest entries combinationally and retires 0, 1 or 2 of them per cycle. A pipeline flush empties the queue, and the `ready` handshake back-pressures fetch so that no accepted beat is ever dropped.

## Interface
Parameters:
- `DEPTH`, default 8: number of 32-bit entries. Must be a power of two and at least 4.
- `CNT_W`, default `$clog2(DEPTH)+1`: width of the occupancy count.

Ports. One clock `clk`; reset `rst` is asynchronous and active-low.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous active-low reset.
- `inst0_i`, input, `XLEN/2`: older instruction of the fetch beat.
- `inst1_i`, input, `XLEN/2`: younger instruction of the fetch beat.
- `inst_valid_i`, input, 1: fetch beat valid.
- `instr_queue_ready_o`, output, 1: at least 2 free entries.
- `flush_i`, input, 1: synchronous flush (branch miss or exception).
- `out0_inst_o`, output, `XLEN/2`: oldest entry.
- `out0_valid_o`, output, 1: count ≥ 1.
- `out1_inst_o`, output, `XLEN/2`: second-oldest entry.
- `out1_valid_o`, output, 1: count ≥ 2.
- `pop_i`, input, 2: number of entries decode retires this cycle (0, 1 or 2; value 3 is treated as 2).
- `count_o`, output, `CNT_W`: current occupancy.
- `perf_full_stall_o`, output, 32: full-stall cycle counter (see Configuration).

## Operation
- Storage is a circular buffer `mem[DEPTH]` with read pointer `rd_ptr`, write pointer `wr_ptr` and counter `count`.
  - Pointers are `$clog2(DEPTH)` bits and wrap naturally modulo `DEPTH`.
- `instr_queue_ready_o = (DEPTH - count) >= 2`. It is combinational from registered `count` only; a same-cycle pop is not credited.
- Push, when `inst_valid_i && instr_queue_ready_o && !flush_i`:
  - `mem[wr_ptr] <= inst0_i` and `mem[wr_ptr+1] <= inst1_i`;
  - `wr_ptr += 2`.
  - A beat with `inst_valid_i` high while ready is low is ignored. Fetch must hold it.
- Pop:
  - Effective pop = min(`pop_i` clamped to 2, `count`).
  - `rd_ptr` advances by the effective pop.
  - A pop beyond occupancy is silently clamped; no error is raised.
- Count update: `count <= count + 2*push - pop_eff`. It never exceeds `DEPTH` and never goes below 0.
- Outputs:
  - `out0_inst_o = mem[rd_ptr]` and `out1_inst_o = mem[rd_ptr+1]`.
  - Each data output is forced to 0 when its valid is low.
- Flush has priority over push and pop in the same cycle: `rd_ptr`, `wr_ptr` and `count` are set to 0. Memory contents are not cleared.
- Push and pop in the same cycle are both applied; a read never returns the entries written that cycle.
- Reset (async, `rst` low): pointers, count and the perf counter are set to 0.
  - Resulting outputs: `out*_valid_o=0`, `out*_inst_o=0`, `count_o=0`, `instr_queue_ready_o=1`.
  - Pushes and pops are ignored while `rst` is low.
  - Reset mid-operation discards all contents.

## Timing
- Write-to-read latency is 1 cycle: a beat accepted at edge N appears on `out*` after edge N.
- The pop takes effect at the edge. Decode samples `out*` and asserts `pop_i` in the same cycle.
- Flush at edge N gives valids = 0 and ready = 1 after edge N.
- No combinational path exists from `inst_valid_i`, `pop_i` or `flush_i` to any output.

## Configuration
- Macro: `IQ_PERF_EN`.
- Defined:
  - `perf_full_stall_o` is a 32-bit counter that increments on every cycle with `inst_valid_i && !instr_queue_ready_o`.
  - It saturates at `32'hFFFF_FFFF`.
  - It is cleared only by reset; flush does not clear it.
- Undefined: no counter logic is compiled in, and `perf_full_stall_o` is tied to `32'h0`.

## Test plan
All scenarios use `DEPTH=8`.
1. **First push.** Release reset, push (`0x11`, `0x22`) → next cycle `out0=0x11` and `out1=0x22`, both valid, `count_o=2`, ready = 1.
2. **Full and odd occupancy.**
   - Four pushes with no pop → `count_o=8`, ready = 0; a fifth beat is ignored, with `count_o` and contents unchanged.
   - Then pop 1 → `count_o=7`, ready still 0.
   - Then pop 1 → `count_o=6`, ready = 1.
3. **Simultaneous push and pop.** At `count_o=2` holding (A, B), push (C, D) with `pop_i=2` → `count_o=2`, `out0=C`, `out1=D`.
4. **Pop clamping.** At `count_o=1`, `pop_i=2` → `count_o=0`, valids 0, no underflow; `pop_i=3` at count 2 gives count 0.
5. **Flush priority.** Flush asserted together with a push and a pop → `count_o=0`, valids 0, outputs 0; the pushed beat is absent next cycle.
6. **Wrap-around and perf counter.**
   - Push twelve ascending pairs while popping 2 per cycle → ordering is preserved across pointer wrap.
   - With `IQ_PERF_EN` defined, 5 stalled valid cycles at full → `perf_full_stall_o=5`.

Source files
------------

// File: rtl/instr_queue.sv
// Two-wide instruction queue between fetch and decode: 2-entry pushes, 0..2 pops per cycle, flush.
// Optional full-stall performance counter compiled in with IQ_PERF_EN.
module instr_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst0_i,
  input  logic [31:0]      inst1_i,
  input  logic             inst_valid_i,
  output logic             instr_queue_ready_o,
  input  logic             flush_i,
  output logic [31:0]      out0_inst_o,
  output logic             out0_valid_o,
  output logic [31:0]      out1_inst_o,
  output logic             out1_valid_o,
  input  logic [1:0]       pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic [31:0]      perf_full_stall_o
);
  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a fetch beat transfers on a rising edge where inst_valid_i and
  // instr_queue_ready_o are both high and flush_i is low; ready depends only on
  // registered occupancy, so fetch must hold an unaccepted beat.

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic [1:0]       pop_req;
  logic [CNT_W-1:0] pop_eff;
  logic [CNT_W-1:0] push_amt;

  assign instr_queue_ready_o = (count_q <= CNT_W'(DEPTH - 2));
  assign push                = inst_valid_i && instr_queue_ready_o && !flush_i;

  always_comb begin
    pop_req  = (pop_i == 2'd3) ? 2'd2 : pop_i;
    pop_eff  = (count_q < CNT_W'(pop_req)) ? count_q : CNT_W'(pop_req);
    push_amt = push ? CNT_W'(2) : CNT_W'(0);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_eff);
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(2) : wr_ptr_q;
    count_d  = count_q + push_amt - pop_eff;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; validity comes from count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]               <= inst0_i;
      mem_q[wr_ptr_q + PTR_W'(1)]   <= inst1_i;
    end
  end

  assign out0_valid_o = (count_q != '0);
  assign out1_valid_o = (count_q >= CNT_W'(2));
  assign out0_inst_o  = out0_valid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign out1_inst_o  = out1_valid_o ? mem_q[rd_ptr_q + PTR_W'(1)] : 32'h0;
  assign count_o      = count_q;

`ifdef IQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (inst_valid_i && !instr_queue_ready_o && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Flush intentionally leaves the counter alone; only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_full_stall_o = perf_q;
`else
  assign perf_full_stall_o = 32'h0;
`endif

endmodule
